bank_scheduler: RTL and testbench

BANK_SCHEDULER -- requirements
Module: bank_scheduler

---
 rtl/bank_sched_pkg.sv | 18 +
 rtl/bank_usage.sv | 70 +++++++
 rtl/bank_scheduler.sv | 146 ++++++++++++++
 tb/tb_bank_scheduler.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bank_sched_pkg.sv
// bank_sched_pkg
//   Shared definitions for the two-bank allocation scheduler:
//   scheduler state encoding, response codes and the default bank capacity.
package bank_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } sched_state_t;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;
    localparam logic [1:0] DECERR = 2'b11;

    localparam logic [63:0] DEFAULT_BANK_SIZE = 64'h0000_0001_0000_0000;

endpackage

// File: rtl/bank_usage.sv
// bank_usage
//   Per-bank bookkeeping: write pointer, bytes in use, high-water mark and a
//   sticky underflow flag.
// Ports:
//   clk, resetn            clock, synchronous active-low reset
//   snapshot               run start: re-arm hwm from the current usage
//   alloc_valid/alloc_len  allocation granted to this bank this cycle
//   free_valid/free_len    bytes released from this bank this cycle
//   used, wptr, hwm        current usage, next write offset, high-water mark
//   underflow              sticky: a release exceeded the usage
module bank_usage
    import bank_sched_pkg::*;
#(
    parameter logic [63:0] BANK_SIZE = DEFAULT_BANK_SIZE,
    parameter int          LEN_W     = 16
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             snapshot,
    input  logic             alloc_valid,
    input  logic [LEN_W-1:0] alloc_len,
    input  logic             free_valid,
    input  logic [LEN_W-1:0] free_len,
    output logic [63:0]      used,
    output logic [63:0]      wptr,
    output logic [63:0]      hwm,
    output logic             underflow
);

    logic [64:0] sum_ext;
    logic [64:0] free_ext;
    logic [64:0] wsum;
    logic        uf_now;
    logic [63:0] used_nxt;
    logic [63:0] wptr_nxt;

    // Allocation and release on the same cycle both apply; the release is
    // checked against usage after the allocation is added.
    always_comb begin
        sum_ext  = {1'b0, used} + (alloc_valid ? 65'(alloc_len) : 65'd0);
        free_ext = free_valid ? 65'(free_len) : 65'd0;
        uf_now   = free_ext > sum_ext;
        used_nxt = uf_now ? 64'd0 : 64'(sum_ext - free_ext);
        wsum     = {1'b0, wptr} + 65'(alloc_len);
        wptr_nxt = (wsum >= {1'b0, BANK_SIZE}) ? 64'(wsum - {1'b0, BANK_SIZE})
                                                : 64'(wsum);
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            used      <= 64'd0;
            wptr      <= 64'd0;
            hwm       <= 64'd0;
            underflow <= 1'b0;
        end else begin
            used <= used_nxt;
            if (alloc_valid)
                wptr <= wptr_nxt;
            if (uf_now)
                underflow <= 1'b1;
            // On a run start the mark restarts from present usage, still
            // honouring any growth landing on the same edge.
            if (snapshot)
                hwm <= (used_nxt > used) ? used_nxt : used;
            else if (used_nxt > hwm)
                hwm <= used_nxt;
        end
    end

endmodule

// File: rtl/bank_scheduler.sv
// bank_scheduler
//   Timed run controller that hands out byte ranges from two RAM banks,
//   preferring the less-used bank, and tracks usage/high-water marks.
//   Optional statistics counters are built only when BANK_SCHEDULER_STATS_EN
//   is defined; otherwise grants_0/grants_1/stall_cycles read 0.
// Ports:
//   clk, resetn                  clock, synchronous active-low reset
//   start, cycle_count           begin a run of cycle_count cycles
//   busy, done                   in RUN / one-cycle end-of-run pulse
//   req_valid, req_len, req_ready  allocation request handshake
//   grant_valid/bank/addr        grant strobe one cycle after acceptance
//   free0_*/free1_*              per-bank release strobes
//   hwm_0, hwm_1, underflow      usage high-water marks, sticky underflow
//   grants_0, grants_1, stall_cycles  statistics
//
// state   | meaning
// IDLE    | waiting for start
// RUN     | counting down, accepting requests while the counter is non-zero
// DONE    | one-cycle end-of-run, done asserted
module bank_scheduler
    import bank_sched_pkg::*;
#(
    parameter logic [63:0] BANK_SIZE = DEFAULT_BANK_SIZE,
    parameter int          LEN_W     = 16
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic [31:0]      cycle_count,
    output logic             busy,
    output logic             done,
    input  logic             req_valid,
    input  logic [LEN_W-1:0] req_len,
    output logic             req_ready,
    output logic             grant_valid,
    output logic             grant_bank,
    output logic [63:0]      grant_addr,
    input  logic             free0_valid,
    input  logic [LEN_W-1:0] free0_len,
    input  logic             free1_valid,
    input  logic [LEN_W-1:0] free1_len,
    output logic [63:0]      hwm_0,
    output logic [63:0]      hwm_1,
    output logic             underflow,
    output logic [31:0]      grants_0,
    output logic [31:0]      grants_1,
    output logic [31:0]      stall_cycles
);

    sched_state_t state, state_nxt;
    logic [31:0]  run_cnt;
    logic [63:0]  used_0, used_1, wptr_0, wptr_1;
    logic         uf_0, uf_1;
    logic [64:0]  len_ext;
    logic         fit_0, fit_1, pref, pref_fit, sel, accept;

    assign len_ext  = 65'(req_len);
    assign fit_0    = ({1'b0, used_0} + len_ext) <= {1'b0, BANK_SIZE};
    assign fit_1    = ({1'b0, used_1} + len_ext) <= {1'b0, BANK_SIZE};
    assign pref     = used_1 < used_0;
    assign pref_fit = pref ? fit_1 : fit_0;
    assign sel      = pref_fit ? pref : ~pref;

    assign busy      = (state == ST_RUN);
    assign done      = (state == ST_DONE);
    assign req_ready = busy && (run_cnt != 32'd0) && (fit_0 || fit_1);
    assign accept    = req_valid && req_ready;
    assign underflow = uf_0 | uf_1;

    // Leaving RUN once the counter is at or about to hit zero gives exactly
    // cycle_count busy cycles, and a single RUN cycle for cycle_count=0.
    always_comb begin
        state_nxt = state;
        if (start) begin
            state_nxt = ST_RUN;
        end else begin
            case (state)
                ST_IDLE: state_nxt = ST_IDLE;
                ST_RUN:  if (run_cnt <= 32'd1) state_nxt = ST_DONE;
                ST_DONE: state_nxt = ST_IDLE;
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state       <= ST_IDLE;
            run_cnt     <= 32'd0;
            grant_valid <= 1'b0;
            grant_bank  <= 1'b0;
            grant_addr  <= 64'd0;
        end else begin
            state       <= state_nxt;
            grant_valid <= accept;
            if (start)
                run_cnt <= cycle_count;
            else if (busy && run_cnt != 32'd0)
                run_cnt <= run_cnt - 32'd1;
            if (accept) begin
                grant_bank <= sel;
                grant_addr <= sel ? wptr_1 : wptr_0;
            end
        end
    end

    bank_usage #(.BANK_SIZE(BANK_SIZE), .LEN_W(LEN_W)) u_bank0 (
        .clk(clk), .resetn(resetn), .snapshot(start),
        .alloc_valid(accept && !sel), .alloc_len(req_len),
        .free_valid(free0_valid), .free_len(free0_len),
        .used(used_0), .wptr(wptr_0), .hwm(hwm_0), .underflow(uf_0)
    );

    bank_usage #(.BANK_SIZE(BANK_SIZE), .LEN_W(LEN_W)) u_bank1 (
        .clk(clk), .resetn(resetn), .snapshot(start),
        .alloc_valid(accept && sel), .alloc_len(req_len),
        .free_valid(free1_valid), .free_len(free1_len),
        .used(used_1), .wptr(wptr_1), .hwm(hwm_1), .underflow(uf_1)
    );

`ifdef BANK_SCHEDULER_STATS_EN
    logic [31:0] grants_0_q, grants_1_q, stall_q;

    always_ff @(posedge clk) begin
        if (!resetn || start) begin
            grants_0_q <= 32'd0;
            grants_1_q <= 32'd0;
            stall_q    <= 32'd0;
        end else begin
            if (accept && !sel) grants_0_q <= grants_0_q + 32'd1;
            if (accept && sel)  grants_1_q <= grants_1_q + 32'd1;
            if (busy && req_valid && !req_ready && stall_q != 32'hFFFF_FFFF)
                stall_q <= stall_q + 32'd1;
        end
    end

    assign grants_0     = grants_0_q;
    assign grants_1     = grants_1_q;
    assign stall_cycles = stall_q;
`else
    assign grants_0     = 32'd0;
    assign grants_1     = 32'd0;
    assign stall_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_bank_scheduler.sv
// tb_bank_scheduler
//   Directed and randomized stimulus for bank_scheduler (BANK_SIZE = 0x400),
//   checked every cycle against a behavioural model of banks, runs and stats.
module tb_bank_scheduler;

    localparam logic [63:0] BSZ = 64'h400;

    logic        clk = 1'b0;
    logic        resetn, start, req_valid, free0_valid, free1_valid;
    logic [31:0] cycle_count;
    logic [15:0] req_len, free0_len, free1_len;
    logic        busy, done, req_ready, grant_valid, grant_bank, underflow;
    logic [63:0] grant_addr, hwm_0, hwm_1;
    logic [31:0] grants_0, grants_1, stall_cycles;

    always #5 clk = ~clk;

    bank_scheduler #(.BANK_SIZE(BSZ), .LEN_W(16)) dut (
        .clk(clk), .resetn(resetn), .start(start), .cycle_count(cycle_count),
        .busy(busy), .done(done),
        .req_valid(req_valid), .req_len(req_len), .req_ready(req_ready),
        .grant_valid(grant_valid), .grant_bank(grant_bank), .grant_addr(grant_addr),
        .free0_valid(free0_valid), .free0_len(free0_len),
        .free1_valid(free1_valid), .free1_len(free1_len),
        .hwm_0(hwm_0), .hwm_1(hwm_1), .underflow(underflow),
        .grants_0(grants_0), .grants_1(grants_1), .stall_cycles(stall_cycles)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: bank contents as plain numbers, run as "cycles left".
    longint unsigned m_used[2], m_wptr[2], m_hwm[2], m_grants[2];
    longint unsigned m_stall, m_left, m_ga;
    bit m_running, m_ending, m_uf, m_gv, m_gb, m_known;

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit m_fits(int b);
        return (m_used[b] + longint'(req_len)) <= BSZ;
    endfunction

    function automatic bit m_ready();
        return m_running && (m_left != 0) && (m_fits(0) || m_fits(1));
    endfunction

    function automatic int m_pick();
        int p;
        p = (m_used[1] < m_used[0]) ? 1 : 0;
        if (m_fits(p)) return p;
        return 1 - p;
    endfunction

    task automatic model_edge();
        bit rdy, acc;
        int b;
        longint unsigned a, f, t, old;
        if (!resetn) begin
            for (int i = 0; i < 2; i++) begin
                m_used[i] = 0; m_wptr[i] = 0; m_hwm[i] = 0; m_grants[i] = 0;
            end
            m_stall = 0; m_left = 0; m_running = 0; m_ending = 0;
            m_uf = 0; m_gv = 0; m_gb = 0; m_ga = 0; m_known = 1;
            return;
        end
        rdy = m_ready();
        acc = req_valid && rdy;
        b = m_pick();
        m_gv = acc;
        if (acc) begin
            m_gb = (b == 1);
            m_ga = m_wptr[b];
            m_wptr[b] = (m_wptr[b] + longint'(req_len)) % BSZ;
        end
        for (int i = 0; i < 2; i++) begin
            a = (acc && b == i) ? longint'(req_len) : 0;
            if (i == 0) f = free0_valid ? longint'(free0_len) : 0;
            else        f = free1_valid ? longint'(free1_len) : 0;
            old = m_used[i];
            t = old + a;
            if (f > t) begin m_used[i] = 0; m_uf = 1; end
            else m_used[i] = t - f;
            if (start) m_hwm[i] = (m_used[i] > old) ? m_used[i] : old;
            else if (m_used[i] > m_hwm[i]) m_hwm[i] = m_used[i];
        end
        if (start) begin
            m_grants[0] = 0; m_grants[1] = 0; m_stall = 0;
        end else begin
            if (acc) m_grants[b]++;
            if (m_running && req_valid && !rdy && m_stall != 64'hFFFF_FFFF) m_stall++;
        end
        if (start) begin
            m_running = 1; m_ending = 0; m_left = cycle_count;
        end else if (m_running) begin
            if (m_left <= 1) begin m_running = 0; m_ending = 1; end
            if (m_left != 0) m_left--;
        end else begin
            m_ending = 0;
        end
    endtask

    task automatic step();
        @(negedge clk);
        if (m_known) chk("req_ready", req_ready, m_ready());
        @(posedge clk);
        model_edge();
        #1;
        chk("busy", busy, m_running);
        chk("done", done, m_ending);
        chk("grant_valid", grant_valid, m_gv);
        if (m_gv || !resetn) begin
            chk("grant_bank", grant_bank, m_gb);
            chk("grant_addr", grant_addr, m_ga);
        end
        chk("hwm_0", hwm_0, m_hwm[0]);
        chk("hwm_1", hwm_1, m_hwm[1]);
        chk("underflow", underflow, m_uf);
`ifdef BANK_SCHEDULER_STATS_EN
        chk("grants_0", grants_0, m_grants[0]);
        chk("grants_1", grants_1, m_grants[1]);
        chk("stall_cycles", stall_cycles, m_stall);
`else
        chk("grants_0", grants_0, 0);
        chk("grants_1", grants_1, 0);
        chk("stall_cycles", stall_cycles, 0);
`endif
        start = 0; free0_valid = 0; free1_valid = 0;
    endtask

    initial begin
        int busy_n, done_at, gi, done_seen;
        logic [63:0] g_addr[4];
        logic        g_bank[4];
        logic [63:0] exp_addr[4];
        logic        exp_bank[4];

        m_known = 0;
        resetn = 0; start = 0; cycle_count = 0; req_valid = 0; req_len = 0;
        free0_valid = 0; free0_len = 0; free1_valid = 0; free1_len = 0;
        step(); step();
        chk("rst_busy", busy, 0);
        chk("rst_hwm_0", hwm_0, 0);
        resetn = 1;
        step();

        // Plain timed run, no traffic.
        start = 1; cycle_count = 10;
        busy_n = 0; done_at = 0;
        for (int i = 1; i <= 13; i++) begin
            step();
            if (busy) busy_n++;
            if (done && done_at == 0) done_at = i;
        end
        chk("busy_cycles", busy_n, 10);
        chk("done_cycle", done_at, 11);

        // Four 0x100 requests alternate between banks.
        start = 1; cycle_count = 40;
        step();
        exp_bank[0] = 0; exp_bank[1] = 1; exp_bank[2] = 0; exp_bank[3] = 1;
        exp_addr[0] = 0; exp_addr[1] = 0; exp_addr[2] = 64'h100; exp_addr[3] = 64'h100;
        gi = 0;
        req_valid = 1; req_len = 16'h100;
        for (int i = 0; i < 6; i++) begin
            if (i == 4) req_valid = 0;
            step();
            if (grant_valid && gi < 4) begin
                g_bank[gi] = grant_bank; g_addr[gi] = grant_addr; gi++;
            end
        end
        chk("grant_count", gi, 4);
        for (int i = 0; i < 4; i++) begin
            chk("seq_bank", g_bank[i], exp_bank[i]);
            chk("seq_addr", g_addr[i], exp_addr[i]);
        end
        chk("hwm_0_200", hwm_0, 64'h200);
        chk("hwm_1_200", hwm_1, 64'h200);

        // Build used_0=0x300, used_1=0x380, then fill bank 0 and stall.
        req_valid = 1; req_len = 16'h100; step();
        req_len = 16'h180; step();
        req_len = 16'h100; step();
        chk("near_full_bank", grant_bank, 0);
        chk("near_full_valid", grant_valid, 1);
        for (int i = 0; i < 5; i++) step();
        chk("stall_ready", req_ready, 0);
`ifdef BANK_SCHEDULER_STATS_EN
        chk("stall_5", stall_cycles, 5);
`else
        chk("stall_off", stall_cycles, 0);
`endif
        req_valid = 0;
        free0_valid = 1; free0_len = 16'h380;
        free1_valid = 1; free1_len = 16'h280;
        step();
        for (int i = 0; i < 30; i++) step();

        // Restart re-arms hwm; same-cycle grant and free on bank 0.
        start = 1; cycle_count = 10; step();
        chk("rearm_hwm_0", hwm_0, 64'h80);
        chk("rearm_hwm_1", hwm_1, 64'h100);
        req_valid = 1; req_len = 16'h40;
        free0_valid = 1; free0_len = 16'h40;
        step();
        req_valid = 0;
        chk("same_cycle_bank", grant_bank, 0);
        chk("same_cycle_hwm", hwm_0, 64'h80);
        step();

        // Free to zero, then over-free.
        free0_valid = 1; free0_len = 16'h80; step();
        chk("no_uf_yet", underflow, 0);
        free0_valid = 1; free0_len = 16'h10; step();
        chk("uf_set", underflow, 1);
        for (int i = 0; i < 12; i++) step();
        chk("uf_sticky", underflow, 1);

        // Reset mid-run, with a request being accepted on the reset edge.
        start = 1; cycle_count = 30; step();
        req_valid = 1; req_len = 16'h20; step(); step();
        resetn = 0; step();
        chk("midrst_gv", grant_valid, 0);
        chk("midrst_uf", underflow, 0);
        resetn = 1; req_valid = 0;
        done_seen = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (done) done_seen++;
        end
        chk("midrst_no_done", done_seen, 0);
        start = 1; cycle_count = 3;
        done_at = 0;
        for (int i = 1; i <= 6; i++) begin
            step();
            if (done && done_at == 0) done_at = i;
        end
        chk("after_rst_done", done_at, 4);

        // Randomized runs with traffic and releases.
        for (int r = 0; r < 6; r++) begin
            start = 1; cycle_count = $urandom_range(60, 10);
            if (r == 2) cycle_count = 0;
            for (int i = 0; i < 70; i++) begin
                req_valid = ($urandom_range(3, 0) != 0);
                case ($urandom_range(7, 0))
                    0:       req_len = 16'h0;
                    1:       req_len = 16'h500;
                    default: req_len = 16'($urandom_range(16'h1ff, 1));
                endcase
                free0_valid = ($urandom_range(3, 0) == 0);
                free0_len   = 16'($urandom_range(16'h140, 0));
                free1_valid = ($urandom_range(3, 0) == 0);
                free1_len   = 16'($urandom_range(16'h140, 0));
                step();
            end
        end
        req_valid = 0;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
